// File: rtl/warp_sched_pkg.sv
// Shared constants, FSM encoding and warp-field helper for the warp issue scheduler.
package warp_sched_pkg;
  localparam int NUM_WARPS        = 4;
  localparam int THREADS_PER_WARP = 8;
  localparam int WARP_ID_W        = 2;
  localparam int MASK_W           = 4;

  typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

  // Warp 0 owns the most significant field of the thread vector.
  function automatic int warp_field_lsb(input logic [WARP_ID_W-1:0] w);
    return (NUM_WARPS - 1 - int'(w)) * THREADS_PER_WARP;
  endfunction
endpackage

// File: rtl/warp_scheduler_if.sv
// Issue-side bundle between readiness/buffer logic, the scheduler and the execution stage.
interface warp_scheduler_if #(parameter int NUM_THREADS = 32);
  import warp_sched_pkg::*;

  logic [NUM_WARPS-1:0]             ready_warps;
  logic [NUM_WARPS-1:0]             instr_valid;
  logic [NUM_WARPS-1:0][MASK_W-1:0] warp_masks;
  logic                             issue_ready;
  logic                             issue_valid;
  logic [WARP_ID_W-1:0]             issue_warp_id;
  logic [MASK_W-1:0]                issue_mask;
  logic [NUM_WARPS-1:0]             instr_pop;
  logic [NUM_THREADS-1:0]           busy_set;

  modport master (
    input  ready_warps, instr_valid, warp_masks, issue_ready,
    output issue_valid, issue_warp_id, issue_mask, instr_pop, busy_set
  );

  modport slave (
    output ready_warps, instr_valid, warp_masks, issue_ready,
    input  issue_valid, issue_warp_id, issue_mask, instr_pop, busy_set
  );
endinterface

// File: rtl/Threads_Mask_Decoder.sv
// Expands a 4-bit issue mask into an 8-thread warp field; each mask bit covers a thread pair.
module Threads_Mask_Decoder
  import warp_sched_pkg::*;
(
  input  logic [MASK_W-1:0]           mask,
  output logic [THREADS_PER_WARP-1:0] threads
);
  for (genvar i = 0; i < THREADS_PER_WARP; i++) begin : g_thr
    assign threads[i] = mask[i/2];
  end
endmodule

// File: rtl/warp_rr_arbiter.sv
// Combinational 4-way round-robin arbiter: rotate by rr_ptr, pick lowest set, rotate back.
module warp_rr_arbiter
  import warp_sched_pkg::*;
(
  input  logic [NUM_WARPS-1:0] eligible,
  input  logic [WARP_ID_W-1:0] rr_ptr,
  output logic                 grant_valid,
  output logic [WARP_ID_W-1:0] grant_id
);
  logic [NUM_WARPS-1:0] rotated;
  logic [WARP_ID_W-1:0] offset;

  always_comb begin
    rotated = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      rotated[i] = eligible[WARP_ID_W'(i) + rr_ptr];
    end
    // Descending scan so the lowest rotated position is the final winner.
    offset = '0;
    for (int i = NUM_WARPS - 1; i >= 0; i--) begin
      if (rotated[i]) offset = WARP_ID_W'(i);
    end
    grant_valid = |eligible;
    grant_id    = rr_ptr + offset;
  end
endmodule

// File: rtl/warp_scheduler.sv
// Round-robin warp issue controller: grant, hold until accepted, then pop buffer and set scoreboard.
module warp_scheduler
  import warp_sched_pkg::*;
#(
  parameter int NUM_THREADS = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 halt,
  output logic                 running,
  output logic [15:0]          issue_count,
  warp_scheduler_if.master     bus
);
  state_t                    state;
  logic [WARP_ID_W-1:0]      rr_ptr;
  logic [NUM_WARPS-1:0]      eligible;
  logic                      grant_valid;
  logic [WARP_ID_W-1:0]      grant_id;
  logic                      handshake;
  logic [THREADS_PER_WARP-1:0] field_threads;

  assign eligible  = bus.ready_warps & bus.instr_valid;
  assign handshake = bus.issue_valid & bus.issue_ready;

  warp_rr_arbiter u_arb (
    .eligible    (eligible),
    .rr_ptr      (rr_ptr),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  Threads_Mask_Decoder u_dec (
    .mask    (bus.issue_mask),
    .threads (field_threads)
  );

  // Pulses come only from registered state plus issue_ready, so they never glitch on arbitration inputs.
  assign bus.instr_pop = handshake ? ({{(NUM_WARPS-1){1'b0}}, 1'b1} << bus.issue_warp_id) : '0;
  assign bus.busy_set  = handshake ?
                         (NUM_THREADS'(field_threads) << warp_field_lsb(bus.issue_warp_id)) : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      rr_ptr            <= '0;
      running           <= 1'b0;
      issue_count       <= '0;
      bus.issue_valid   <= 1'b0;
      bus.issue_warp_id <= '0;
      bus.issue_mask    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !halt) begin
            state       <= RUN;
            running     <= 1'b1;
            issue_count <= '0;
          end
        end
        RUN: begin
          if (halt) begin
            state   <= IDLE;
            running <= 1'b0;
          end else if (grant_valid) begin
            state             <= HOLD;
            bus.issue_valid   <= 1'b1;
            bus.issue_warp_id <= grant_id;
            bus.issue_mask    <= bus.warp_masks[grant_id];
          end
        end
        HOLD: begin
          // The issue is committed: inputs and halt are only looked at once it is accepted.
          if (bus.issue_ready) begin
            bus.issue_valid <= 1'b0;
            rr_ptr          <= bus.issue_warp_id + 1'b1;
            issue_count     <= issue_count + 16'd1;
            if (halt) begin
              state   <= IDLE;
              running <= 1'b0;
            end else begin
              state <= RUN;
            end
          end
        end
        default: begin
          state           <= IDLE;
          running         <= 1'b0;
          bus.issue_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_warp_scheduler.sv
// Directed plus randomized bench for warp_scheduler against a transaction-level reference model.
module tb_warp_scheduler;
  import warp_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, halt;
  logic        running;
  logic [15:0] issue_count;

  warp_scheduler_if #(.NUM_THREADS(32)) bus ();

  warp_scheduler #(.NUM_THREADS(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt        (halt),
    .running     (running),
    .issue_count (issue_count),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: 0 = idle, 1 = arbitrating, 2 = issue outstanding.
  int          m_mode;
  int          m_ptr;
  int          m_id;
  logic [3:0]  m_mask;
  int          m_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_ptr = 0; m_id = 0; m_mask = 4'h0; m_count = 0;
  endtask

  task automatic check_outputs();
    bit          hs;
    logic [3:0]  exp_pop;
    logic [31:0] exp_busy;
    hs = (m_mode == 2) && (bus.issue_ready === 1'b1);
    exp_pop = 4'h0;
    if (hs) exp_pop[m_id] = 1'b1;
    for (int t = 0; t < 32; t++)
      exp_busy[t] = hs && ((31 - t) / 8 == m_id) && m_mask[(t % 8) / 2];
    chk("issue_valid", 32'(bus.issue_valid), 32'(m_mode == 2));
    chk("issue_warp_id", 32'(bus.issue_warp_id), 32'(m_id));
    chk("issue_mask", 32'(bus.issue_mask), 32'(m_mask));
    chk("running", 32'(running), 32'(m_mode != 0));
    chk("issue_count", 32'(issue_count), 32'(m_count % 65536));
    chk("instr_pop", 32'(bus.instr_pop), 32'(exp_pop));
    chk("busy_set", bus.busy_set, exp_busy);
  endtask

  task automatic model_step();
    int  w;
    bit  found;
    case (m_mode)
      0: if (start && !halt) begin m_mode = 1; m_count = 0; end
      1: begin
        if (halt) m_mode = 0;
        else begin
          found = 0;
          for (int k = 0; k < 4; k++) begin
            w = (m_ptr + k) % 4;
            if (!found && bus.ready_warps[w] && bus.instr_valid[w]) begin
              found = 1; m_id = w; m_mask = bus.warp_masks[w];
            end
          end
          if (found) m_mode = 2;
        end
      end
      default: if (bus.issue_ready) begin
        m_ptr = (m_id + 1) % 4;
        m_count++;
        m_mode = halt ? 0 : 1;
      end
    endcase
  endtask

  // Inputs are set just after a rising edge; outputs are compared on the falling edge.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_masks();
    for (int w = 0; w < 4; w++) bus.warp_masks[w] = 4'($urandom);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; halt = 1'b0;
    bus.ready_warps = 4'h0; bus.instr_valid = 4'h0; bus.issue_ready = 1'b0;
    for (int w = 0; w < 4; w++) bus.warp_masks[w] = 4'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;

    // All warps eligible, execution always ready: strict 0,1,2,3,0 rotation.
    bus.ready_warps = 4'hF; bus.instr_valid = 4'hF; bus.issue_ready = 1'b1;
    rand_masks();
    start = 1'b1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 1) chk("t1_grant_seq", 32'(bus.issue_warp_id), 32'((i / 2) % 4));
      rand_masks();
      cycle();
    end
    bus.ready_warps = 4'h0;
    cycle();
    chk("t1_count", 32'(issue_count), 32'd5);

    // Bring rr_ptr to 2, then only warps 0/1 eligible.
    bus.ready_warps = 4'b0010;
    cycle(); cycle();
    bus.ready_warps = 4'b0011;
    cycle();
    chk("t2_grant_wrap", 32'(bus.issue_warp_id), 32'd0);
    cycle();
    cycle();
    chk("t2_grant_next", 32'(bus.issue_warp_id), 32'd1);
    cycle();

    // Stalled issue of warp 3 survives readiness dropping.
    bus.ready_warps = 4'b1000; bus.issue_ready = 1'b0;
    bus.warp_masks[3] = 4'b1010;
    cycle();
    bus.ready_warps = 4'h0;
    rand_masks();
    repeat (5) cycle();
    chk("t3_hold_valid", 32'(bus.issue_valid), 32'd1);
    chk("t3_hold_id", 32'(bus.issue_warp_id), 32'd3);
    bus.issue_ready = 1'b1;
    #1;
    chk("t3_pop", 32'(bus.instr_pop), 32'b1000);
    chk("t3_busy", bus.busy_set, 32'h0000_00CC);
    cycle();
    chk("t3_pop_pulse", 32'(bus.instr_pop), 32'd0);

    // Halt during HOLD completes the issue, then idles.
    bus.ready_warps = 4'hF; bus.issue_ready = 1'b0;
    cycle();
    halt = 1'b1;
    cycle();
    bus.issue_ready = 1'b1;
    cycle();
    chk("t4_halt_hold", 32'(running), 32'd0);
    halt = 1'b0;
    start = 1'b1;
    cycle();
    start = 1'b0; halt = 1'b1;
    cycle();
    chk("t4_halt_run", 32'(running), 32'd0);
    chk("t4_halt_noissue", 32'(bus.issue_valid), 32'd0);

    // start with halt stays idle; start alone clears the count.
    start = 1'b1;
    cycle();
    chk("t5_start_halt", 32'(running), 32'd0);
    start = 1'b0; halt = 1'b0;
    cycle();
    start = 1'b1; bus.ready_warps = 4'h0;
    cycle();
    start = 1'b0;
    chk("t5_count_clear", 32'(issue_count), 32'd0);
    chk("t5_running", 32'(running), 32'd1);

    // Asynchronous reset while an issue is outstanding.
    bus.ready_warps = 4'hF; bus.issue_ready = 1'b0;
    cycle();
    chk("t6_in_hold", 32'(bus.issue_valid), 32'd1);
    bus.issue_ready = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(bus.issue_valid), 32'd0);
    chk("t6_rst_pop", 32'(bus.instr_pop), 32'd0);
    chk("t6_rst_busy", bus.busy_set, 32'd0);
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();

    // Randomized traffic.
    start = 1'b1;
    cycle();
    for (int i = 0; i < 400; i++) begin
      bus.ready_warps = 4'($urandom);
      bus.instr_valid = 4'($urandom) | 4'($urandom);
      bus.issue_ready = ($urandom % 4) != 0;
      halt            = ($urandom % 20) == 0;
      start           = ($urandom % 8) == 0;
      rand_masks();
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
